// File: rtl/exe_pkg.sv
// Shared execution-unit types: result flags and the two-entry buffer states.
package exe_pkg;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic p;
    } flags_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/exe_flag_gen.sv
// Combinational status-flag generator {C,Z,N,P} for a signed operator result.
module exe_flag_gen
    import exe_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic [LEN-1:0] result_i,
    input  logic           carry_i,
    output flags_t         flags_o
);

    logic [3:0] flags_v;

    always_comb begin
        flags_v         = 4'b0000;
        flags_v[FLAG_C] = carry_i;
        flags_v[FLAG_Z] = (result_i == '0);
        flags_v[FLAG_N] = result_i[LEN-1];
        flags_v[FLAG_P] = ^result_i;
    end

    assign flags_o = flags_t'(flags_v);

endmodule

// File: rtl/exe_result_stage.sv
// Registered two-entry skid buffer between the execution unit and the SPI shifter.
// Optional sticky-flag accumulator enabled by defining EXE_RESULT_STICKY_FLAGS_EN.
//
// state | meaning
// EMPTY | no entries held, o_valid low
// ONE   | head entry valid, room for one more
// FULL  | head and tail valid, o_ready low
module exe_result_stage
    import exe_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int DEPTH = 2
) (
    input  logic           i_clk,
    input  logic           i_rsn,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [LEN-1:0] i_result,
    input  logic           i_carry,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [LEN-1:0] o_result,
    output logic [3:0]     o_flags,
    input  logic           i_clr_flags,
    output logic [3:0]     o_sticky
);

    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("exe_result_stage: DEPTH must be 2");
        end
        if (LEN < 2) begin : g_bad_len
            $error("exe_result_stage: LEN must be >= 2");
        end
    endgenerate

    buf_state_t     state_q;
    logic           ready_q;
    logic [LEN-1:0] head_res_q, tail_res_q;
    flags_t         head_flags_q, tail_flags_q;
    flags_t         flags_in;
    logic           push, pop;

    exe_flag_gen #(.LEN(LEN)) u_flag_gen (
        .result_i (i_result),
        .carry_i  (i_carry),
        .flags_o  (flags_in)
    );

    assign push = i_valid && ready_q;
    assign pop  = (state_q != EMPTY) && i_ready;

    // ready_q tracks "next state != FULL" so o_ready never depends on i_ready.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_q      <= EMPTY;
            ready_q      <= 1'b0;
            head_res_q   <= '0;
            tail_res_q   <= '0;
            head_flags_q <= '0;
            tail_flags_q <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_res_q   <= i_result;
                        head_flags_q <= flags_in;
                        state_q      <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_res_q   <= i_result;
                        head_flags_q <= flags_in;
                    end else if (push) begin
                        tail_res_q   <= i_result;
                        tail_flags_q <= flags_in;
                        state_q      <= FULL;
                        ready_q      <= 1'b0;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_res_q   <= tail_res_q;
                        head_flags_q <= tail_flags_q;
                        state_q      <= ONE;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign o_valid  = (state_q != EMPTY);
    assign o_ready  = ready_q;
    assign o_result = head_res_q;
    assign o_flags  = head_flags_q;

`ifdef EXE_RESULT_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    // Clear takes effect before the same-edge push is ORed in.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            sticky_q <= 4'b0000;
        end else begin
            sticky_q <= (i_clr_flags ? 4'b0000 : sticky_q) | (push ? flags_in : 4'b0000);
        end
    end

    assign o_sticky = sticky_q;
`else
    logic unused_clr_flags;
    assign unused_clr_flags = i_clr_flags;
    assign o_sticky         = 4'b0000;
`endif

endmodule

// File: tb/tb_exe_result_stage.sv
// Self-checking bench for exe_result_stage: queue-based model plus directed literal checks.
module tb_exe_result_stage;

    localparam int LEN = 4;

    logic           i_clk = 1'b0;
    logic           i_rsn;
    logic           i_valid;
    logic           o_ready;
    logic [LEN-1:0] i_result;
    logic           i_carry;
    logic           o_valid;
    logic           i_ready;
    logic [LEN-1:0] o_result;
    logic [3:0]     o_flags;
    logic           i_clr_flags;
    logic [3:0]     o_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    exe_result_stage #(.LEN(LEN), .DEPTH(2)) dut (
        .i_clk       (i_clk),
        .i_rsn       (i_rsn),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result    (i_result),
        .i_carry     (i_carry),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_flags     (o_flags),
        .i_clr_flags (i_clr_flags),
        .o_sticky    (o_sticky)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Flags from the arithmetic definition of the result value.
    function automatic logic [3:0] model_flags(input logic [LEN-1:0] r, input logic c);
        int v;
        v = int'(r);
        return {c, (v == 0), (v >= (1 << (LEN-1))), ($countones(r) % 2 == 1)};
    endfunction

    logic [LEN+3:0] q[$];
    logic           rdy_m;
    logic [3:0]     sticky_m;

    always @(posedge i_clk or negedge i_rsn) begin
        bit push_m, pop_m;
        if (!i_rsn) begin
            q.delete();
            rdy_m    = 1'b0;
            sticky_m = 4'b0000;
        end else begin
            push_m = i_valid && rdy_m;
            pop_m  = (q.size() > 0) && i_ready;
`ifdef EXE_RESULT_STICKY_FLAGS_EN
            if (i_clr_flags) sticky_m = 4'b0000;
            if (push_m) sticky_m = sticky_m | model_flags(i_result, i_carry);
`endif
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back({i_result, model_flags(i_result, i_carry)});
            rdy_m = (q.size() < 2);
        end
    end

    always @(negedge i_clk) begin
        chk("valid", o_valid, (q.size() > 0));
        chk("ready", o_ready, rdy_m);
        chk("sticky", o_sticky, sticky_m);
        if (q.size() > 0) begin
            chk("result", o_result, q[0][LEN+3:4]);
            chk("flags", o_flags, q[0][3:0]);
        end
        if (!i_rsn) begin
            chk("rst_result", o_result, 0);
            chk("rst_flags", o_flags, 0);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_one(input logic [LEN-1:0] r, input logic c);
        i_valid  = 1'b1;
        i_result = r;
        i_carry  = c;
        step();
        i_valid  = 1'b0;
        i_result = 'x;
    endtask

    initial begin
        i_rsn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_result = '0; i_carry = 1'b0; i_clr_flags = 1'b0;
        step(); step();
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        i_rsn = 1'b1;
        step();
        chk("ready_after_rst", o_ready, 1);

        // single push of zero with carry, immediate drain
        i_ready = 1'b1;
        push_one(4'b0000, 1'b1);
        chk("t1_valid", o_valid, 1);
        chk("t1_result", o_result, 4'b0000);
        chk("t1_flags", o_flags, 4'b1100);
        step();
        chk("t1_drained", o_valid, 0);

        // stalled entry stays stable
        i_ready = 1'b0;
        push_one(4'b1011, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t2_flags", o_flags, 4'b0011);
            chk("t2_result", o_result, 4'b1011);
            step();
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("t2_drained", o_valid, 0);

        // fill to FULL; third result held off until drain
        i_valid = 1'b1; i_carry = 1'b0;
        i_result = 4'd3; step();
        i_result = 4'd5; step();
        chk("t3_full_ready", o_ready, 0);
        i_result = 4'd7; step(); step();
        chk("t3_head3", o_result, 4'd3);
        i_ready = 1'b1; step();
        chk("t3_head5", o_result, 4'd5);
        chk("t3_ready_back", o_ready, 1);
        step();
        chk("t3_head7", o_result, 4'd7);
        i_valid = 1'b0; i_result = 'x; step();
        chk("t3_empty", o_valid, 0);

        // push+pop while holding one entry
        i_ready = 1'b0;
        push_one(4'd2, 1'b0);
        chk("t4_head2", o_result, 4'd2);
        i_ready = 1'b1;
        push_one(4'd6, 1'b0);
        i_ready = 1'b0;
        chk("t4_head6", o_result, 4'd6);
        chk("t4_one_ready", o_ready, 1);
        i_ready = 1'b1; step(); i_ready = 1'b0;

        // async reset while FULL
        push_one(4'd9, 1'b0);
        push_one(4'd10, 1'b0);
        chk("t5_full", o_ready, 0);
        #2 i_rsn = 1'b0;
        #1;
        chk("t5_rst_valid", o_valid, 0);
        chk("t5_rst_result", o_result, 0);
        chk("t5_rst_flags", o_flags, 0);
        step(); step();
        i_rsn = 1'b1;
        step();
        i_ready = 1'b1;
        push_one(4'b1101, 1'b1);
        chk("t5_new_result", o_result, 4'b1101);
        chk("t5_new_flags", o_flags, 4'b1011);
        step();
        chk("t5_empty", o_valid, 0);

        // pseudo-random handshake traffic checked by the model
        for (int k = 0; k < 60; k++) begin
            i_valid  = ($urandom_range(0, 3) != 0);
            i_ready  = ($urandom_range(0, 2) != 0);
            i_result = i_valid ? LEN'($urandom) : 'x;
            i_carry  = $urandom_range(0, 1) == 1;
            step();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        step(); step(); step();
        chk("rand_drained", o_valid, 0);

`ifdef EXE_RESULT_STICKY_FLAGS_EN
        i_clr_flags = 1'b1; step(); i_clr_flags = 1'b0;
        chk("s_cleared", o_sticky, 4'b0000);
        push_one(4'b0000, 1'b0);
        chk("s_zero", o_sticky, 4'b0100);
        push_one(4'b1000, 1'b0);
        chk("s_neg", o_sticky, 4'b0111);
        i_clr_flags = 1'b1;
        push_one(4'b0001, 1'b0);
        i_clr_flags = 1'b0;
        chk("s_clr_push", o_sticky, 4'b0001);
`else
        i_clr_flags = 1'b1;
        push_one(4'b0000, 1'b1);
        i_clr_flags = 1'b0;
        chk("s_off", o_sticky, 4'b0000);
`endif
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
